main_memory: RTL and testbench

MAIN_MEMORY -- requirements
Module: main_memory

---
 rtl/main_memory_if.sv | 20 ++
 rtl/main_memory.sv | 76 +++++++
 tb/tb_main_memory.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/main_memory_if.sv
// Scan-loaded byte memory bus: serial scan chain controls plus the dual-byte read port.
// The master drives scan and address inputs; the slave (memory) returns scan_out and the two read bytes.
interface main_memory_if;
   logic       scan_in;
   logic       scan_en;
   logic       scan_out;
   logic [7:0] addr;
   logic [7:0] d_out_0;
   logic [7:0] d_out_1;

   modport master (
      output scan_in, scan_en, addr,
      input  scan_out, d_out_0, d_out_1
   );

   modport slave (
      input  scan_in, scan_en, addr,
      output scan_out, d_out_0, d_out_1
   );
endinterface

// File: rtl/main_memory.sv
// LEN-byte memory loaded only through a serial scan chain, read two adjacent bytes at a time.
// Define MAIN_MEMORY_OUT_REG_EN to register d_out_0/d_out_1 (one clk latency, reset to 0x00).
module main_memory #(
   parameter int LEN = 64
) (
   input  logic         clk,
   input  logic         reset,
   main_memory_if.slave bus
);
   localparam int AW = (LEN > 1) ? $clog2(LEN) : 1;
   localparam int NB = LEN * 8;

   if (LEN < 2 || LEN > 256 || (LEN & (LEN - 1)) != 0) begin : g_bad_len
      $error("main_memory: LEN must be a power of two in 2..256");
   end

   // mem[k] occupies chain bits [8k+7:8k], so one left shift of the flat
   // vector moves each byte's MSB into the next byte's LSB.
   logic [NB-1:0] chain_q;
   logic [NB-1:0] chain_d;

   always_comb begin
      chain_d = chain_q;
      if (bus.scan_en) begin
         chain_d = {chain_q[NB-2:0], bus.scan_in};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         chain_q <= '0;
      end else begin
         chain_q <= chain_d;
      end
   end

   assign bus.scan_out = chain_q[NB-1];

   // Index arithmetic stays AW bits wide so addr+1 wraps from LEN-1 to 0.
   logic [AW-1:0] idx0;
   logic [AW-1:0] idx1;
   logic [7:0]    d0_d;
   logic [7:0]    d1_d;

   assign idx0 = bus.addr[AW-1:0];
   assign idx1 = idx0 + AW'(1);
   assign d0_d = chain_q[{idx0, 3'b000} +: 8];
   assign d1_d = chain_q[{idx1, 3'b000} +: 8];

   if (AW < 8) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^bus.addr[7:AW];
   end

`ifdef MAIN_MEMORY_OUT_REG_EN
   logic [7:0] d0_q;
   logic [7:0] d1_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         d0_q <= 8'h00;
         d1_q <= 8'h00;
      end else begin
         d0_q <= d0_d;
         d1_q <= d1_d;
      end
   end

   assign bus.d_out_0 = d0_q;
   assign bus.d_out_1 = d1_q;
`else
   assign bus.d_out_0 = d0_d;
   assign bus.d_out_1 = d1_d;
`endif

endmodule

// File: tb/tb_main_memory.sv
// Directed, table-driven bench for main_memory (LEN=64): reset, scan load, wrap/alias reads,
// scan_out, hold, and asynchronous reset during a load.
module tb_main_memory;
   logic clk;
   logic reset;
   int   checks;
   int   failures;

   main_memory_if bus ();

   main_memory #(.LEN(64)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] addr;
      logic [7:0] e0;
      logic [7:0] e1;
   } vec_t;

   vec_t tbl [8];

   task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
      end
   endtask

   // Present an address and wait for the read to become visible.
   task automatic set_addr(input logic [7:0] a);
      bus.addr = a;
`ifdef MAIN_MEMORY_OUT_REG_EN
      @(posedge clk);
      #1;
`else
      #1;
`endif
   endtask

   task automatic check_read(input string name, input logic [7:0] a,
                             input logic [7:0] e0, input logic [7:0] e1);
      set_addr(a);
      check8({name, "_d0"}, bus.d_out_0, e0);
      check8({name, "_d1"}, bus.d_out_1, e1);
   endtask

   // Called at posedge+1; leaves scan_en asserted.
   task automatic shift_bit(input logic b);
      bus.scan_in = b;
      bus.scan_en = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic load_descending();
      logic [7:0] b;
      for (int v = 63; v >= 0; v--) begin
         b = v[7:0];
         for (int k = 7; k >= 0; k--) shift_bit(b[k]);
      end
      bus.scan_en = 1'b0;
   endtask

   task automatic run_table(input string tag);
      for (int i = 0; i < 8; i++) begin
         check_read($sformatf("%s_addr%0d", tag, tbl[i].addr), tbl[i].addr, tbl[i].e0, tbl[i].e1);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      checks   = 0;
      failures = 0;
      // After loading 63..0 MSB first, mem[k] = k.
      tbl[0] = '{8'd5,   8'h05, 8'h06};
      tbl[1] = '{8'd63,  8'h3F, 8'h00};
      tbl[2] = '{8'd200, 8'h08, 8'h09};
      tbl[3] = '{8'd0,   8'h00, 8'h01};
      tbl[4] = '{8'd64,  8'h00, 8'h01};
      tbl[5] = '{8'd255, 8'h3F, 8'h00};
      tbl[6] = '{8'd127, 8'h3F, 8'h00};
      tbl[7] = '{8'd32,  8'h20, 8'h21};

      reset       = 1'b0;
      bus.scan_in = 1'b0;
      bus.scan_en = 1'b0;
      bus.addr    = 8'd0;
      #1;
      check8("in_reset_scan_out", {7'd0, bus.scan_out}, 8'h00);
      check8("in_reset_d0", bus.d_out_0, 8'h00);
      check8("in_reset_d1", bus.d_out_1, 8'h00);
      @(posedge clk);
      #1;
      reset = 1'b1;

      // Reset state across every address
      for (int a = 0; a < 256; a++) begin
         check_read($sformatf("rst_addr%0d", a), a[7:0], 8'h00, 8'h00);
      end
      check8("rst_scan_out", {7'd0, bus.scan_out}, 8'h00);

      // Load and read back through the table
      load_descending();
`ifdef MAIN_MEMORY_OUT_REG_EN
      check_read("pre_latency", 8'd10, 8'h0A, 8'h0B);
      bus.addr = 8'd5;
      #1;
      check8("latency_before_edge", bus.d_out_0, 8'h0A);
      @(posedge clk);
      #1;
      check8("latency_after_edge", bus.d_out_0, 8'h05);
`endif
      run_table("load");
      check8("load_scan_out", {7'd0, bus.scan_out}, 8'h00);

      // Hold with scan_in toggling
      for (int c = 0; c < 20; c++) begin
         bus.scan_in = c[0];
         @(posedge clk);
         #1;
      end
      run_table("hold");

      // Scan-out: mem[63]=0x3F, bit 5 reaches the MSB after two shifts
      shift_bit(1'b0);
      check8("scan_out_1shift", {7'd0, bus.scan_out}, 8'h00);
      shift_bit(1'b0);
      check8("scan_out_2shift", {7'd0, bus.scan_out}, 8'h01);
      bus.scan_en = 1'b0;
      check_read("after_2shift", 8'd1, 8'h04, 8'h08);

      // Asynchronous reset in the middle of a load
      bus.scan_in = 1'b1;
      bus.scan_en = 1'b1;
      repeat (6) @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      check8("async_rst_scan_out", {7'd0, bus.scan_out}, 8'h00);
      check8("async_rst_d0", bus.d_out_0, 8'h00);
      check8("async_rst_d1", bus.d_out_1, 8'h00);
      repeat (2) @(posedge clk);
      #1;
      check8("held_rst_d0", bus.d_out_0, 8'h00);
      check8("held_rst_scan_out", {7'd0, bus.scan_out}, 8'h00);
      reset = 1'b1;
      shift_bit(1'b1);
      bus.scan_en = 1'b0;
      check8("resume_scan_out", {7'd0, bus.scan_out}, 8'h00);
      check_read("resume_addr0", 8'd0, 8'h01, 8'h00);
      check_read("resume_addr63", 8'd63, 8'h00, 8'h01);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
